// File: rtl/i2c_target_responder_pkg.sv
// Shared definitions for the I2C target responder: FSM state encoding,
// default target address, and glitch filter depth.
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ADDR      = 3'd1,
        ST_ADDR_ACK  = 3'd2,
        ST_WRITE     = 3'd3,
        ST_WRITE_ACK = 3'd4,
        ST_READ      = 3'd5,
        ST_READ_ACK  = 3'd6,
        ST_WAIT_STOP = 3'd7
    } i2c_state_e;

    localparam logic [6:0] DEFAULT_ADDR = 7'b1001010;
    localparam int         FILTER_DEPTH = 3;

    // True when the address byte (address in [7:1], R/W in [0]) selects addr.
    function automatic logic addr_hit(input logic [7:0] addr_byte, input logic [6:0] addr);
        return addr_byte[7:1] == addr;
    endfunction

endpackage

// File: rtl/i2c_target_responder_if.sv
// Register-side bus of the I2C target: SCL input plus the byte
// handshake seen by the surrounding logic. SDA stays a plain inout on
// the top because it is a resolved open-drain net.
interface i2c_target_responder_if;
    logic       scl;
    logic [7:0] tx_data;
    logic       tx_load;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       addr_match;
    logic       busy;

    modport slave (
        input  scl, tx_data,
        output tx_load, rx_data, rx_valid, addr_match, busy
    );

    modport master (
        output scl, tx_data,
        input  tx_load, rx_data, rx_valid, addr_match, busy
    );
endinterface

// File: rtl/i2c_target_responder_line.sv
// i2c_line_conditioner: brings one I2C line into the clk domain with a
// 2-flop synchronizer and produces level/rise/fall. With
// I2C_TARGET_GLITCH_FILTER_EN defined, the level only follows the line
// after FILTER_DEPTH consecutive equal samples, rejecting short pulses.
module i2c_line_conditioner
    import i2c_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic line_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta;
    logic level_d;

`ifdef I2C_TARGET_GLITCH_FILTER_EN
    // hist[0] is the second synchronizer stage; deeper bits are older samples.
    logic [FILTER_DEPTH-2:0] hist;
    logic                    held;
    logic [FILTER_DEPTH-1:0] win;

    assign win = {hist, meta};

    // Synchronizer chain, sample history, and held filter value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta    <= 1'b1;
            hist    <= '1;
            held    <= 1'b1;
            level_d <= 1'b1;
        end else begin
            meta    <= line_in;
            hist    <= {hist[FILTER_DEPTH-3:0], meta};
            held    <= level;
            level_d <= level;
        end
    end

    // Follow the line only once the whole window agrees.
    always_comb begin
        level = held;
        if (&win)
            level = 1'b1;
        else if (~|win)
            level = 1'b0;
    end
`else
    logic sync_q;

    // Plain 2-flop synchronizer plus previous level for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta    <= 1'b1;
            sync_q  <= 1'b1;
            level_d <= 1'b1;
        end else begin
            meta    <= line_in;
            sync_q  <= meta;
            level_d <= level;
        end
    end

    assign level = sync_q;
`endif

    assign rise = level & ~level_d;
    assign fall = ~level & level_d;

endmodule

// File: rtl/i2c_target_responder.sv
// I2C target responder: emulates a TMP101-style target at SLAVE_ADDR.
// Detects START/STOP, ACKs its address, receives write bytes or sends
// read bytes. SDA is open-drain (driven low or released only).
// Optional macro: I2C_TARGET_GLITCH_FILTER_EN (3-sample line filter).
//
// state        | meaning
// IDLE         | bus free, SDA released, waiting for START
// ADDR         | shifting in the address byte on SCL rises
// ADDR_ACK     | driving ACK for a matched address
// WRITE        | shifting in a write data byte
// WRITE_ACK    | driving ACK for a received data byte
// READ         | shifting TxData out on SCL falls
// READ_ACK     | sampling the controller's ACK/NACK
// WAIT_STOP    | not addressed or NACKed, waiting for STOP/START
module i2c_target_responder
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = DEFAULT_ADDR
) (
    input  logic                    clk,
    input  logic                    rst_n,
    i2c_target_responder_if.slave   bus,
    inout  wire                     sda
);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;

    i2c_line_conditioner u_scl (
        .clk     (clk),
        .rst_n   (rst_n),
        .line_in (bus.scl),
        .level   (scl_lvl),
        .rise    (scl_rise),
        .fall    (scl_fall)
    );

    i2c_line_conditioner u_sda (
        .clk     (clk),
        .rst_n   (rst_n),
        .line_in (sda),
        .level   (sda_lvl),
        .rise    (sda_rise),
        .fall    (sda_fall)
    );

    i2c_state_e state, state_nxt;
    logic [7:0] shreg, shreg_nxt;
    logic [2:0] bit_cnt, bit_cnt_nxt;
    logic       sda_oe, sda_oe_nxt;
    logic [7:0] rx_data, rx_data_nxt;
    logic       rx_valid, rx_valid_nxt;
    logic       tx_load, tx_load_nxt;
    logic       addr_match, addr_match_nxt;
    logic       busy, busy_nxt;
    logic       rw, rw_nxt;
    logic       load_pend, load_pend_nxt;

    logic       scl_edge;
    logic       start_det;
    logic       stop_det;
    logic       last_bit;
    logic [7:0] byte_in;

    // An SDA edge coinciding with an SCL edge is a data edge, not START/STOP.
    assign scl_edge  = scl_rise | scl_fall;
    assign start_det = sda_fall & scl_lvl & ~scl_edge;
    assign stop_det  = sda_rise & scl_lvl & ~scl_edge;
    assign last_bit  = (bit_cnt == 3'd7);
    assign byte_in   = {shreg[6:0], sda_lvl};

    assign sda = sda_oe ? 1'b0 : 1'bz;

    assign bus.tx_load    = tx_load;
    assign bus.rx_data    = rx_data;
    assign bus.rx_valid   = rx_valid;
    assign bus.addr_match = addr_match;
    assign bus.busy       = busy;

    // State and datapath registers; reset releases SDA immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            shreg      <= 8'h00;
            bit_cnt    <= 3'd0;
            sda_oe     <= 1'b0;
            rx_data    <= 8'h00;
            rx_valid   <= 1'b0;
            tx_load    <= 1'b0;
            addr_match <= 1'b0;
            busy       <= 1'b0;
            rw         <= 1'b0;
            load_pend  <= 1'b0;
        end else begin
            state      <= state_nxt;
            shreg      <= shreg_nxt;
            bit_cnt    <= bit_cnt_nxt;
            sda_oe     <= sda_oe_nxt;
            rx_data    <= rx_data_nxt;
            rx_valid   <= rx_valid_nxt;
            tx_load    <= tx_load_nxt;
            addr_match <= addr_match_nxt;
            busy       <= busy_nxt;
            rw         <= rw_nxt;
            load_pend  <= load_pend_nxt;
        end
    end

    // Next-state and output logic; START/STOP override every state.
    always_comb begin
        state_nxt      = state;
        shreg_nxt      = shreg;
        bit_cnt_nxt    = bit_cnt;
        sda_oe_nxt     = sda_oe;
        rx_data_nxt    = rx_data;
        rx_valid_nxt   = 1'b0;
        tx_load_nxt    = 1'b0;
        addr_match_nxt = addr_match;
        busy_nxt       = busy;
        rw_nxt         = rw;
        load_pend_nxt  = load_pend;

        if (start_det) begin
            state_nxt      = ST_ADDR;
            bit_cnt_nxt    = 3'd0;
            sda_oe_nxt     = 1'b0;
            busy_nxt       = 1'b1;
            addr_match_nxt = 1'b0;
            load_pend_nxt  = 1'b0;
        end else if (stop_det) begin
            state_nxt      = ST_IDLE;
            sda_oe_nxt     = 1'b0;
            busy_nxt       = 1'b0;
            addr_match_nxt = 1'b0;
            load_pend_nxt  = 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_WAIT_STOP: begin
                    sda_oe_nxt = 1'b0;
                end

                ST_ADDR: begin
                    if (scl_rise) begin
                        shreg_nxt   = byte_in;
                        bit_cnt_nxt = bit_cnt + 3'd1;
                        if (last_bit) begin
                            bit_cnt_nxt = 3'd0;
                            rw_nxt      = sda_lvl;
                            state_nxt   = addr_hit(byte_in, SLAVE_ADDR) ? ST_ADDR_ACK
                                                                        : ST_WAIT_STOP;
                        end
                    end
                end

                // First fall starts the ACK, second fall ends it.
                ST_ADDR_ACK: begin
                    if (scl_fall) begin
                        if (!sda_oe) begin
                            sda_oe_nxt     = 1'b1;
                            addr_match_nxt = 1'b1;
                        end else if (rw) begin
                            shreg_nxt   = bus.tx_data;
                            tx_load_nxt = 1'b1;
                            sda_oe_nxt  = ~bus.tx_data[7];
                            bit_cnt_nxt = 3'd0;
                            state_nxt   = ST_READ;
                        end else begin
                            sda_oe_nxt  = 1'b0;
                            bit_cnt_nxt = 3'd0;
                            state_nxt   = ST_WRITE;
                        end
                    end
                end

                ST_WRITE: begin
                    if (scl_rise) begin
                        shreg_nxt   = byte_in;
                        bit_cnt_nxt = bit_cnt + 3'd1;
                        if (last_bit) begin
                            bit_cnt_nxt  = 3'd0;
                            rx_data_nxt  = byte_in;
                            rx_valid_nxt = 1'b1;
                            state_nxt    = ST_WRITE_ACK;
                        end
                    end
                end

                ST_WRITE_ACK: begin
                    if (scl_fall) begin
                        if (!sda_oe) begin
                            sda_oe_nxt = 1'b1;
                        end else begin
                            sda_oe_nxt  = 1'b0;
                            bit_cnt_nxt = 3'd0;
                            state_nxt   = ST_WRITE;
                        end
                    end
                end

                // bit_cnt counts bits already put on the line after bit 7.
                ST_READ: begin
                    if (scl_fall) begin
                        if (load_pend) begin
                            shreg_nxt     = bus.tx_data;
                            tx_load_nxt   = 1'b1;
                            sda_oe_nxt    = ~bus.tx_data[7];
                            bit_cnt_nxt   = 3'd0;
                            load_pend_nxt = 1'b0;
                        end else if (last_bit) begin
                            sda_oe_nxt  = 1'b0;
                            bit_cnt_nxt = 3'd0;
                            state_nxt   = ST_READ_ACK;
                        end else begin
                            shreg_nxt   = {shreg[6:0], 1'b0};
                            sda_oe_nxt  = ~shreg[6];
                            bit_cnt_nxt = bit_cnt + 3'd1;
                        end
                    end
                end

                ST_READ_ACK: begin
                    if (scl_rise) begin
                        if (!sda_lvl) begin
                            state_nxt     = ST_READ;
                            load_pend_nxt = 1'b1;
                        end else begin
                            state_nxt = ST_WAIT_STOP;
                        end
                    end
                end

                default: begin
                    state_nxt  = ST_IDLE;
                    sda_oe_nxt = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_target_responder.sv
// Bench for i2c_target_responder: bit-banged I2C controller, randomized
// transactions, and a transaction-level expectation model.
module tb_i2c_target_responder;

    localparam logic [6:0] TGT_ADDR = 7'h4A;
    localparam int         Q        = 8;
`ifdef I2C_TARGET_GLITCH_FILTER_EN
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic ctl_low = 1'b0;
    wire  sda;

    always #5 clk = ~clk;

    i2c_target_responder_if bus();

    assign sda = ctl_low ? 1'b0 : 1'bz;
    pullup (sda);

    i2c_target_responder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .sda   (sda)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    int n_txload  = 0;
    int n_rxvalid = 0;
    int n_dutlow  = 0;

    logic [7:0] model_rx = 8'h00;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) begin
        if (bus.tx_load)  n_txload  <= n_txload + 1;
        if (bus.rx_valid) n_rxvalid <= n_rxvalid + 1;
        if (sda == 1'b0 && !ctl_low) n_dutlow <= n_dutlow + 1;
    end

    initial begin
        repeat (200000) @(posedge clk);
        $display("FAIL watchdog: bench exceeded cycle budget");
        $fatal(1, "watchdog");
    end

    task automatic quarter();
        repeat (Q) @(negedge clk);
    endtask

    task automatic i2c_start();
        ctl_low = 1'b0;
        quarter();
        bus.scl = 1'b1;
        quarter();
        ctl_low = 1'b1;
        quarter();
        bus.scl = 1'b0;
        quarter();
    endtask

    task automatic i2c_stop();
        ctl_low = 1'b1;
        quarter();
        bus.scl = 1'b1;
        quarter();
        ctl_low = 1'b0;
        quarter();
        quarter();
    endtask

    task automatic send_bit(input bit b, input bit glitch);
        ctl_low = !b;
        quarter();
        bus.scl = 1'b1;
        if (glitch) begin
            repeat (3) @(negedge clk);
            bus.scl = 1'b0;
            repeat (2) @(negedge clk);
            bus.scl = 1'b1;
            repeat (2*Q-5) @(negedge clk);
        end else begin
            repeat (2*Q) @(negedge clk);
        end
        bus.scl = 1'b0;
        quarter();
    endtask

    task automatic recv_bit(output bit b);
        ctl_low = 1'b0;
        quarter();
        bus.scl = 1'b1;
        quarter();
        b = sda;
        quarter();
        bus.scl = 1'b0;
        quarter();
    endtask

    task automatic write_byte(input logic [7:0] d, input int glitch_bit, output bit ack);
        bit b;
        for (int i = 7; i >= 0; i--) send_bit(d[i], i == glitch_bit);
        recv_bit(b);
        ack = !b;
    endtask

    task automatic read_byte(output logic [7:0] d, input bit ack, input logic [7:0] next_tx);
        bit b;
        for (int i = 7; i >= 0; i--) begin
            recv_bit(b);
            d[i] = b;
        end
        bus.tx_data = next_tx;
        send_bit(!ack, 1'b0);
    endtask

    // One complete transaction; data holds byte k at [8k+7:8k].
    task automatic run_txn(input logic [6:0] a7, input bit rw, input int n,
                           input logic [23:0] data, input int glitch_bit);
        bit         own, exp_ack, ack;
        int         b_tx, b_rx, b_low;
        logic [7:0] got, nxt;

        own     = (a7 == TGT_ADDR);
        exp_ack = own && (glitch_bit < 0 || FILT);
        b_tx    = n_txload;
        b_rx    = n_rxvalid;
        b_low   = n_dutlow;

        bus.tx_data = data[7:0];
        i2c_start();
        chk("busy_after_start", bus.busy, 1);
        write_byte({a7, rw}, glitch_bit, ack);
        chk("addr_ack", ack, exp_ack);
        chk("addr_match", bus.addr_match, exp_ack);

        for (int k = 0; k < n; k++) begin
            if (!rw) begin
                write_byte(data[k*8 +: 8], -1, ack);
                chk("data_ack", ack, exp_ack);
                if (exp_ack) model_rx = data[k*8 +: 8];
            end else begin
                nxt = (k < 2) ? data[(k+1)*8 +: 8] : 8'($urandom);
                read_byte(got, k < n-1, nxt);
                chk("read_data", got, exp_ack ? data[k*8 +: 8] : 8'hFF);
            end
        end
        chk("addr_match_before_stop", bus.addr_match, exp_ack);
        i2c_stop();

        chk("busy_after_stop", bus.busy, 0);
        chk("addr_match_after_stop", bus.addr_match, 0);
        chk("rx_valid_count", n_rxvalid - b_rx, (!rw && exp_ack) ? n : 0);
        chk("tx_load_count", n_txload - b_tx, (rw && exp_ack) ? n : 0);
        chk("rx_data", bus.rx_data, model_rx);
        if (!exp_ack) chk("sda_never_driven", n_dutlow - b_low, 0);
    endtask

    initial begin
        bit         ack, b;
        int         b_tx, b_rx;
        logic [7:0] got;
        logic [6:0] a7;

        bus.scl     = 1'b1;
        bus.tx_data = 8'h00;

        repeat (5) @(negedge clk);
        chk("rst_sda", sda, 1);
        chk("rst_busy", bus.busy, 0);
        chk("rst_addr_match", bus.addr_match, 0);
        chk("rst_rx_data", bus.rx_data, 8'h00);
        chk("rst_rx_valid", bus.rx_valid, 0);
        chk("rst_tx_load", bus.tx_load, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Read A5 (ACK) then 3C (NACK).
        run_txn(TGT_ADDR, 1'b1, 2, {8'h00, 8'h3C, 8'hA5}, -1);
        // Write 5E.
        run_txn(TGT_ADDR, 1'b0, 1, {16'h0000, 8'h5E}, -1);
        // Foreign address 8'b10010001.
        run_txn(7'b1001000, 1'b1, 1, {16'h0000, 8'h77}, -1);
        run_txn(7'b1001000, 1'b0, 2, {8'h00, 8'h12, 8'h34}, -1);

        for (int t = 0; t < 10; t++) begin
            a7 = TGT_ADDR;
            if ($urandom_range(0, 3) == 0) begin
                a7 = 7'($urandom);
                if (a7 == TGT_ADDR) a7 = a7 ^ 7'h01;
            end
            run_txn(a7, 1'($urandom), int'($urandom_range(1, 3)), 24'($urandom), -1);
        end

        // Repeated START after three write data bits, then read C3.
        b_tx = n_txload;
        b_rx = n_rxvalid;
        i2c_start();
        write_byte({TGT_ADDR, 1'b0}, -1, ack);
        chk("rs_write_addr_ack", ack, 1);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        bus.tx_data = 8'hC3;
        i2c_start();
        chk("rs_addr_match_cleared", bus.addr_match, 0);
        write_byte({TGT_ADDR, 1'b1}, -1, ack);
        chk("rs_read_addr_ack", ack, 1);
        read_byte(got, 1'b0, 8'h00);
        chk("rs_read_data", got, 8'hC3);
        i2c_stop();
        chk("rs_rx_valid_count", n_rxvalid - b_rx, 0);
        chk("rs_tx_load_count", n_txload - b_tx, 1);
        chk("rs_rx_data", bus.rx_data, model_rx);

        // Reset during read bit 4 of an all-zero byte.
        bus.tx_data = 8'h00;
        i2c_start();
        write_byte({TGT_ADDR, 1'b1}, -1, ack);
        chk("rst_mid_addr_ack", ack, 1);
        for (int i = 0; i < 3; i++) recv_bit(b);
        chk("rst_mid_sda_low_before", sda, 0);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_sda_released", sda, 1);
        @(negedge clk);
        chk("rst_mid_busy", bus.busy, 0);
        chk("rst_mid_addr_match", bus.addr_match, 0);
        chk("rst_mid_rx_data", bus.rx_data, 8'h00);
        chk("rst_mid_rx_valid", bus.rx_valid, 0);
        chk("rst_mid_tx_load", bus.tx_load, 0);
        model_rx = 8'h00;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        run_txn(TGT_ADDR, 1'b0, 1, {16'h0000, 8'h9A}, -1);

        // SCL glitch inside the first address bit.
        run_txn(TGT_ADDR, 1'b0, 1, {16'h0000, 8'h5E}, 7);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
